pixel_cfg_sclk_seq: RTL and testbench
=====================================

# pixel_cfg_sclk_seq

Sequencer for the pixel-configuration serial clock. It replaces the fixed divide-by-5 clock with a single-edge, runtime-programmable divider and gates it into bursts of exactly N pulses per configuration transaction. Each burst ends with a load strobe and a done pulse. It sits between the configuration register bank (start, divide ratio, bit count) and the pixel-config shift logic that consumes sclk, bit_adv and load.

## Interface
Parameters:
- DIV_W, 8: width of the divide-ratio input.
- CNT_W, 16: width of the bit-count input and bits_sent.

Ports:
- clkin  in  1  system clock; all logic on posedge only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transaction; sampled only in IDLE.
- abort  in  1  synchronous cancel; sampled in every state.
- div  in  DIV_W  clkin cycles per sclk period; latched at start; values 0 and 1 are clamped to 2.
- nbits  in  CNT_W  sclk pulses in the burst; latched at start.
- busy  out  1  high in LOW, HIGH and LOAD states.
- sclk  out  1  registered serial clock; low outside a burst.
- sclk_rise  out  1  one-cycle pulse in the first HIGH cycle of each bit.
- sclk_fall  out  1  one-cycle pulse in the first LOW cycle following each HIGH phase.
- bit_adv  out  1  one-cycle pulse telling the shift logic to present the next bit; equals sclk_fall for bits 2..N only.
- load  out  1  high during the LOAD state.
- done  out  1  one-cycle pulse at normal completion.
- bits_sent  out  CNT_W  count of sclk_rise events since the last start.

## Operation
- Reset value of every output is 0, and the state is IDLE.
- Latched ratio d = max(div, 2).
- LOW phase length L = ceil(d/2); HIGH phase length H = floor(d/2). For d=5: L=3, H=2. For d=2: L=1, H=1.
- FSM transitions:
  - IDLE → LOW when start=1 and nbits≠0. bits_sent clears to 0 in the same transition.
  - IDLE → DONE when start=1 and nbits=0.
  - LOW → HIGH after L cycles.
  - HIGH → LOW after H cycles if the remaining bit count > 0.
  - HIGH → LOAD after H cycles once the last bit has completed.
  - LOAD → DONE after d cycles.
  - DONE → IDLE after 1 cycle.
- Output decode:
  - sclk = (state==HIGH).
  - load = (state==LOAD).
  - done = (state==DONE).
- bits_sent increments on each sclk_rise. It holds its value after done and after abort.
- The first data bit must be presented by the shift logic before start. Each bit_adv moves to the next bit during LOW, so data is stable at the next rising sclk edge.
- start is ignored in every state except IDLE. div and nbits changes during a burst have no effect.
- abort=1 in any state: next state is IDLE. In that cycle sclk, load and busy go to 0, and no done pulse is generated.
- abort and start together in IDLE: abort wins and the block stays IDLE.
- rst mid-burst: all outputs 0 on the next cycle, including bits_sent.
- nbits=2^CNT_W−1 and div=2^DIV_W−1 must work. The phase counter is DIV_W bits and the bit counter is CNT_W bits, with no overflow.

## Timing
- start sampled at cycle T (nbits=N≥1, ratio d):
  - busy and LOW begin at T+1.
  - The first sclk_rise is at T+1+L.
  - Bit k (1-based) rises at T+1+(k−1)·d+L.
  - LOAD occupies T+1+N·d … T+N·d+d.
  - done is at T+1+(N+1)·d, and busy=0 in that cycle.
- nbits=0: done at T+1. No sclk, no load, and busy is never asserted.
- A new start is accepted at the earliest in the cycle after done, i.e. back in IDLE.
- Output latency: all outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.

## Structure
- Shared package pixel_cfg_pkg:
  - state enum {IDLE, LOW, HIGH, LOAD, DONE}.
  - DIV_MIN = 2.
  - Default widths DIV_W and CNT_W.
- Sub-module pixel_cfg_phase_cnt: a loadable down-counter for phase length, with load value and terminal-count output. It is reused for L, H and the LOAD duration.
- The top module holds the FSM, the bit counter, bits_sent and the edge-pulse decode.

## Test plan
- div=5, nbits=3, start at T: sclk pattern 0,0,0,1,1 repeated three times from T+1; sclk_rise at T+4, T+9, T+14; bit_adv at T+6 and T+11 only; load high for T+16..T+20; done at T+21; bits_sent=3.
- div=0 (clamped to 2), nbits=4: sclk toggles every cycle starting T+1 (1 low, 1 high); done at T+11.
- nbits=0: done at T+1; sclk, load and busy stay 0 throughout.
- abort in the second HIGH cycle of bit 2 with div=5, nbits=8: next cycle IDLE with all outputs 0 except bits_sent=2; no done pulse; a subsequent start runs a full burst normally.
- start pulsed again mid-burst and div changed mid-burst: timing is unchanged from the original burst. start and abort asserted together in IDLE: the block stays IDLE.
- rst asserted during LOAD: all outputs 0 next cycle. div=255, nbits=2: done at T+1+3·255.

Source files
------------

// File: rtl/pixel_cfg_pkg.sv
// Shared types and constants for the pixel-configuration serial clock sequencer.
package pixel_cfg_pkg;

    localparam int unsigned DEF_DIV_W = 8;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DIV_MIN   = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LOAD,
        DONE
    } state_e;

endpackage

// File: rtl/pixel_cfg_sclk_seq_if.sv
// Control/status bundle between the config register bank, the sequencer and the shift logic.
interface pixel_cfg_sclk_seq_if #(
    parameter int unsigned DIV_W = pixel_cfg_pkg::DEF_DIV_W,
    parameter int unsigned CNT_W = pixel_cfg_pkg::DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] nbits;
    logic             busy;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             bit_adv;
    logic             load;
    logic             done;
    logic [CNT_W-1:0] bits_sent;

    modport master (
        output start, abort, div, nbits,
        input  busy, sclk, sclk_rise, sclk_fall, bit_adv, load, done, bits_sent
    );

    modport slave (
        input  start, abort, div, nbits,
        output busy, sclk, sclk_rise, sclk_fall, bit_adv, load, done, bits_sent
    );
endinterface

// File: rtl/pixel_cfg_phase_cnt.sv
// Loadable down-counter timing one phase; tc_c flags the last cycle of the loaded length.
module pixel_cfg_phase_cnt #(
    parameter int unsigned W = pixel_cfg_pkg::DEF_DIV_W
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c = (cnt_q == W'(1));
endmodule

// File: rtl/pixel_cfg_sclk_seq.sv
// Programmable sclk divider that emits gated bursts of N pulses, then a load strobe and done.
module pixel_cfg_sclk_seq
    import pixel_cfg_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                 clkin,
    input  logic                 rst,
    pixel_cfg_sclk_seq_if.slave  bus
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] d_q, d_in;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] bits_q;
    logic             ph_load;
    logic [DIV_W-1:0] ph_val;
    logic             ph_tc_c;
    logic             accept_c;
    logic busy_q, sclk_q, rise_q, fall_q, adv_q, load_q, done_q;

    // LOW gets the odd cycle of an odd ratio.
    function automatic logic [DIV_W-1:0] lo_len(input logic [DIV_W-1:0] d);
        return (d >> 1) + DIV_W'(d[0]);
    endfunction

    function automatic logic [DIV_W-1:0] hi_len(input logic [DIV_W-1:0] d);
        return d >> 1;
    endfunction

    assign d_in     = (bus.div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.div;
    assign accept_c = (state_q == IDLE) && bus.start && !bus.abort;

    pixel_cfg_phase_cnt #(.W(DIV_W)) u_phase (
        .clkin    (clkin),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .tc_c     (ph_tc_c)
    );

    // Next state and phase-counter reload on every entry into a timed state.
    always_comb begin
        state_d = state_q;
        ph_load = 1'b0;
        ph_val  = '0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.nbits != '0) begin
                        state_d = LOW;
                        ph_load = 1'b1;
                        ph_val  = lo_len(d_in);
                    end else begin
                        state_d = DONE;
                    end
                end
                LOW: if (ph_tc_c) begin
                    state_d = HIGH;
                    ph_load = 1'b1;
                    ph_val  = hi_len(d_q);
                end
                HIGH: if (ph_tc_c) begin
                    ph_load = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = LOAD;
                        ph_val  = d_q;
                    end else begin
                        state_d = LOW;
                        ph_val  = lo_len(d_q);
                    end
                end
                LOAD: if (ph_tc_c) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, burst bookkeeping and registered output decode of the next state.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= DIV_W'(DIV_MIN);
            rem_q   <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            adv_q   <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                d_q    <= d_in;
                rem_q  <= bus.nbits;
                bits_q <= '0;
            end else begin
                if (state_q == HIGH && state_d == LOW) rem_q <= rem_q - CNT_W'(1);
                if (state_q != HIGH && state_d == HIGH) bits_q <= bits_q + CNT_W'(1);
            end
            busy_q <= (state_d inside {LOW, HIGH, LOAD});
            sclk_q <= (state_d == HIGH);
            rise_q <= (state_q != HIGH) && (state_d == HIGH);
            fall_q <= (state_q == HIGH) && (state_d inside {LOW, LOAD});
            adv_q  <= (state_q == HIGH) && (state_d == LOW);
            load_q <= (state_d == LOAD);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.sclk      = sclk_q;
    assign bus.sclk_rise = rise_q;
    assign bus.sclk_fall = fall_q;
    assign bus.bit_adv   = adv_q;
    assign bus.load      = load_q;
    assign bus.done      = done_q;
    assign bus.bits_sent = bits_q;
endmodule

// File: tb/tb_pixel_cfg_sclk_seq.sv
// Randomized bench comparing the sequencer cycle by cycle against an arithmetic burst-timing model.
module tb_pixel_cfg_sclk_seq;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_cfg_sclk_seq_if #(.DIV_W(DW), .CNT_W(CW)) bus();

    pixel_cfg_sclk_seq #(.DIV_W(DW), .CNT_W(CW)) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    int n_vec     = 0;
    int n_err     = 0;
    int last_bits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output vector order: {busy, sclk, sclk_rise, sclk_fall, bit_adv, load, done}.
    task automatic check_cycle(input string tag, input logic [6:0] e, input int bits);
        logic [6:0] got;
        got = {bus.busy, bus.sclk, bus.sclk_rise, bus.sclk_fall, bus.bit_adv, bus.load, bus.done};
        chk({tag, ".outs"}, 32'(got), 32'(e));
        chk({tag, ".bits"}, 32'(bus.bits_sent), 32'(bits));
    endtask

    // Expected outputs t cycles after the start cycle, from the burst timing rules.
    task automatic model(input int d, input int n, input int t, output logic [6:0] e, output int eb);
        int lo, k, p;
        lo = d - d / 2;
        e  = '0;
        eb = 0;
        if (n == 0) begin
            e[0] = (t == 1);
        end else if (t <= n * d) begin
            k    = (t - 1) / d;
            p    = (t - 1) % d;
            e[6] = 1'b1;
            e[5] = (p >= lo);
            e[4] = (p == lo);
            e[3] = (p == 0) && (k > 0);
            e[2] = (p == 0) && (k > 0);
            eb   = k + ((p >= lo) ? 1 : 0);
        end else if (t <= (n + 1) * d) begin
            e[6] = 1'b1;
            e[1] = 1'b1;
            e[3] = (t == n * d + 1);
            eb   = n;
        end else begin
            e[0] = 1'b1;
            eb   = n;
        end
    endtask

    // One transaction; kind 1 aborts, kind 2 resets, in cycle cut_at (0 = never).
    task automatic txn(input int d_raw, input int n, input int cut_at, input int kind, input bit noise);
        int d, last, eb;
        logic [6:0] e;
        d    = (d_raw < 2) ? 2 : d_raw;
        last = (n == 0) ? 1 : (n + 1) * d + 1;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.div   = DW'(d_raw);
        bus.nbits = CW'(n);
        step();
        bus.start = 1'b0;
        for (int t = 1; t <= last; t++) begin
            model(d, n, t, e, eb);
            check_cycle($sformatf("d%0d_n%0d_t%0d", d_raw, n, t), e, eb);
            if (noise) begin
                bus.start = 1'($urandom);
                bus.div   = DW'($urandom);
                bus.nbits = CW'($urandom);
            end
            if (t == cut_at) begin
                if (kind == 1) bus.abort = 1'b1;
                else rst = 1'b1;
                step();
                bus.abort = 1'b0;
                bus.start = 1'b0;
                rst       = 1'b0;
                last_bits = (kind == 1) ? eb : 0;
                check_cycle($sformatf("cut%0d_d%0d_n%0d_t%0d", kind, d_raw, n, t), '0, last_bits);
                step();
                check_cycle("after_cut", '0, last_bits);
                return;
            end
            step();
        end
        bus.start = 1'b0;
        last_bits = n;
        check_cycle($sformatf("idle_d%0d_n%0d", d_raw, n), '0, n);
    endtask

    initial begin
        int d, n, kind, cut;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.div   = '0;
        bus.nbits = '0;
        repeat (3) step();
        check_cycle("reset", '0, 0);
        rst = 1'b0;
        step();
        check_cycle("reset_idle", '0, 0);

        txn(5, 3, 0, 0, 1'b0);
        txn(0, 4, 0, 0, 1'b0);
        txn(3, 0, 0, 0, 1'b0);
        txn(5, 8, 10, 1, 1'b0);
        txn(5, 8, 0, 0, 1'b0);
        txn(5, 3, 0, 0, 1'b1);

        // start and abort together while idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_cycle("start_abort_idle", '0, last_bits);
        step();
        check_cycle("start_abort_idle2", '0, last_bits);

        txn(5, 3, 17, 2, 1'b0);
        txn(255, 2, 0, 0, 1'b0);
        txn(1, 1, 0, 0, 1'b0);
        txn(2, 1, 0, 0, 1'b0);

        repeat (40) begin
            d    = int'($urandom_range(0, 12));
            n    = int'($urandom_range(0, 6));
            kind = int'($urandom_range(0, 3));
            cut  = int'($urandom_range(1, ((n + 1) * ((d < 2) ? 2 : d)) + 1));
            if (kind < 2) txn(d, n, 0, 0, kind[0]);
            else txn(d, n, cut, kind - 1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
